// File: rtl/ds_reg_write_sequencer.sv
`timescale 1ns/1ps
// ds_reg_write_sequencer
//
// Converts 16-bit register-write requests (valid/ready) into the delta-sigma
// DAC top's byte-wide two-phase write protocol. The low byte is presented with
// data_part high. data_part then falls and the DAC latches the low byte. The
// high byte is then presented and data_part rises, which makes the DAC commit
// {hi, lo} to the addressed register. Every phase is stretched to cover the
// DAC's input synchronizer and edge detector.
//
// Optional build macro: DS_SEQ_FIFO_EN
//   When it is defined, a FIFO_DEPTH-entry request FIFO sits in front of the
//   FSM. Queued writes then run back to back with no IDLE cycle in between.
//
// Parameters:
//   ADDR_BITS     register address width
//   SETUP_CYCLES  cycles data/addr are stable before each data_part edge (>=1)
//   HOLD_CYCLES   cycles data_part is held after each edge (>=4)
//   FIFO_DEPTH    request FIFO depth, power of 2, >=2 (DS_SEQ_FIFO_EN only)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_valid/s_ready   request handshake; accepted when both are high at posedge
//   s_addr, s_data    target register address and 16-bit value
//   data_out          byte to DAC ui_in
//   addr_out          address to DAC uio_in[ADDR_BITS:1]
//   data_part_out     phase toggle to DAC uio_in[4] (idles high)
//   busy              write in progress (or requests queued)
//   write_done        one-cycle pulse in the final HOLD_HI cycle of each write
module ds_reg_write_sequencer #(
    parameter int ADDR_BITS    = 3,
    parameter int SETUP_CYCLES = 1,
    parameter int HOLD_CYCLES  = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [ADDR_BITS-1:0] s_addr,
    input  logic [15:0]          s_data,
    output logic [7:0]           data_out,
    output logic [ADDR_BITS-1:0] addr_out,
    output logic                 data_part_out,
    output logic                 busy,
    output logic                 write_done
);

    if (SETUP_CYCLES < 1) begin : g_bad_setup
        $fatal(1, "ds_reg_write_sequencer: SETUP_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 4) begin : g_bad_hold
        $fatal(1, "ds_reg_write_sequencer: HOLD_CYCLES must be >= 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "ds_reg_write_sequencer: FIFO_DEPTH must be a power of 2, >= 2");
    end

    localparam int CNT_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP_LO,
        HOLD_LO,
        SETUP_HI,
        HOLD_HI
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [7:0]           data_hi, data_hi_nxt;
    logic [7:0]           data_out_nxt;
    logic [ADDR_BITS-1:0] addr_out_nxt;
    logic                 part_nxt;
    logic                 done_nxt;
    logic                 ready_nxt;
    logic                 busy_nxt;

    // Request source feeding the FSM: either the FIFO head or the port itself.
    logic                 avail;
    logic                 take;
    logic [ADDR_BITS-1:0] src_addr;
    logic [15:0]          src_data;

`ifdef DS_SEQ_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [ADDR_BITS+15:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count, count_nxt;
    logic                  push;

    assign push                 = s_valid && s_ready;
    assign avail                = (count != '0);
    assign {src_addr, src_data} = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {s_addr, s_data};
        end
    end

    always_comb begin
        count_nxt = count;
        if (push && !take) begin
            count_nxt = count + (PTR_W + 1)'(1);
        end else if (!push && take) begin
            count_nxt = count - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (take) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    always_comb begin
        ready_nxt = (count_nxt != FULL_CNT);
        busy_nxt  = (state_nxt != IDLE) || (count_nxt != '0);
    end
`else
    // s_ready is only high in IDLE, so a handshake implies the FSM is idle.
    assign avail    = s_valid && s_ready;
    assign src_addr = s_addr;
    assign src_data = s_data;

    always_comb begin
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
    end
`endif

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        data_hi_nxt  = data_hi;
        data_out_nxt = data_out;
        addr_out_nxt = addr_out;
        part_nxt     = data_part_out;
        done_nxt     = 1'b0;
        take         = 1'b0;
        case (state)
            IDLE: begin
                if (avail) begin
                    take         = 1'b1;
                    state_nxt    = SETUP_LO;
                    cnt_nxt      = SETUP_LOAD;
                    data_out_nxt = src_data[7:0];
                    data_hi_nxt  = src_data[15:8];
                    addr_out_nxt = src_addr;
                end
            end
            SETUP_LO: begin
                if (cnt == '0) begin
                    state_nxt = HOLD_LO;
                    cnt_nxt   = HOLD_LOAD;
                    part_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HOLD_LO: begin
                if (cnt == '0) begin
                    state_nxt    = SETUP_HI;
                    cnt_nxt      = SETUP_LOAD;
                    data_out_nxt = data_hi;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            SETUP_HI: begin
                if (cnt == '0) begin
                    state_nxt = HOLD_HI;
                    cnt_nxt   = HOLD_LOAD;
                    part_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HOLD_HI: begin
                // write_done is registered, so raise it one count early to
                // land in the final HOLD_HI cycle.
                done_nxt = (cnt == CNT_W'(1));
                if (cnt == '0) begin
                    state_nxt = IDLE;
`ifdef DS_SEQ_FIFO_EN
                    // Chain straight into the next queued write.
                    if (avail) begin
                        take         = 1'b1;
                        state_nxt    = SETUP_LO;
                        cnt_nxt      = SETUP_LOAD;
                        data_out_nxt = src_data[7:0];
                        data_hi_nxt  = src_data[15:8];
                        addr_out_nxt = src_addr;
                    end
`endif
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            data_hi       <= '0;
            data_out      <= '0;
            addr_out      <= '0;
            data_part_out <= 1'b1;
            write_done    <= 1'b0;
            busy          <= 1'b0;
            s_ready       <= 1'b1;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            data_hi       <= data_hi_nxt;
            data_out      <= data_out_nxt;
            addr_out      <= addr_out_nxt;
            data_part_out <= part_nxt;
            write_done    <= done_nxt;
            busy          <= busy_nxt;
            s_ready       <= ready_nxt;
        end
    end

endmodule

// File: tb/tb_ds_reg_write_sequencer.sv
`timescale 1ns/1ps
// Bench for ds_reg_write_sequencer: two instances (default timing and
// SETUP=2/HOLD=6), each driven by its own stimulus process and observed by a
// behavioural DAC model whose register commits are scoreboarded against
// expected writes.
module tb_ds_reg_write_sequencer;
    localparam int ADDR_BITS = 3;
`ifdef DS_SEQ_FIFO_EN
    localparam int FIFO_MODE = 1;
`else
    localparam int FIFO_MODE = 0;
`endif

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int S      = (g == 0) ? 1 : 2;
        localparam int H      = (g == 0) ? 4 : 6;
        localparam int PER    = 2 * (S + H);
        localparam int OFF    = FIFO_MODE;
        localparam int NBURST = FIFO_MODE ? 6 : 4;

        logic                 rst_n, s_valid, s_ready, data_part_out, busy, write_done;
        logic [ADDR_BITS-1:0] s_addr, addr_out;
        logic [15:0]          s_data;
        logic [7:0]           data_out;
        logic                 done_flag = 1'b0;

        ds_reg_write_sequencer #(
            .ADDR_BITS   (ADDR_BITS),
            .SETUP_CYCLES(S),
            .HOLD_CYCLES (H),
            .FIFO_DEPTH  (4)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .s_valid      (s_valid),
            .s_ready      (s_ready),
            .s_addr       (s_addr),
            .s_data       (s_data),
            .data_out     (data_out),
            .addr_out     (addr_out),
            .data_part_out(data_part_out),
            .busy         (busy),
            .write_done   (write_done)
        );

        logic [ADDR_BITS+15:0] exp_q[$];
        int                    done_q[$];
        logic [15:0]           ref_reg [8];
        logic [15:0]           dac_reg [8];
        logic [7:0]            wr_mask;
        logic [2:0]            sync;
        logic [7:0]            lo_byte;
        logic                  prev_part;
        int                    toggles = 0;

        // DAC model: synchronize data_part, latch the low byte on its falling
        // edge and commit {hi, lo} on its rising edge; reset with the DUT.
        always @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync <= 3'b111;
            end else begin
                sync <= {sync[1:0], data_part_out};
                if (sync[2] && !sync[1]) lo_byte <= data_out;
                if (!sync[2] && sync[1]) begin
                    dac_reg[addr_out] <= {data_out, lo_byte};
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL commit_unexpected: got addr %0d data 0x%0h, expected no write",
                                 addr_out, {data_out, lo_byte});
                    end else begin
                        chk("commit", 32'({addr_out, data_out, lo_byte}), 32'(exp_q.pop_front()));
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (write_done === 1'b1) done_q.push_back(cyc);
            if (data_part_out !== prev_part) toggles++;
            prev_part <= data_part_out;
        end

        task automatic send(input logic [ADDR_BITS-1:0] a, input logic [15:0] d, output int acc_cyc);
            int t = 0;
            s_valid = 1'b1;
            s_addr  = a;
            s_data  = d;
            while (s_ready !== 1'b1 && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("send_ready_wait", 32'(t < 200), 32'd1);
            if (t < 200) begin
                exp_q.push_back({a, d});
                ref_reg[a] = d;
                wr_mask[a] = 1'b1;
            end
            @(negedge clk);
            acc_cyc = cyc;
        endtask

        task automatic wait_idle();
            int t = 0;
            @(negedge clk);
            while ((busy !== 1'b0 || exp_q.size() != 0) && t < 500) begin
                @(negedge clk);
                t++;
            end
            chk("idle_reached", 32'(t < 500), 32'd1);
        endtask

        task automatic chk_reset_vals(input string tag);
            chk({tag, "_part"},  32'(data_part_out), 32'd1);
            chk({tag, "_data"},  32'(data_out),      32'd0);
            chk({tag, "_addr"},  32'(addr_out),      32'd0);
            chk({tag, "_busy"},  32'(busy),          32'd0);
            chk({tag, "_done"},  32'(write_done),    32'd0);
            chk({tag, "_ready"}, 32'(s_ready),       32'd1);
        endtask

        initial begin
            int                   a0;
            int                   k;
            int                   acc[$];
            logic [ADDR_BITS-1:0] ra;
            logic [15:0]          rd;
            rst_n   = 1'b0;
            s_valid = 1'b0;
            s_addr  = '0;
            s_data  = '0;
            wr_mask = '0;
            repeat (3) @(negedge clk);
            chk_reset_vals("in_reset");
            rst_n = 1'b1;
            @(negedge clk);
            chk_reset_vals("after_reset");

            toggles = 0;
            repeat (100) @(negedge clk);
            chk("idle_toggles", 32'(toggles), 32'd0);
            chk_reset_vals("idle_100");

            // Single write, checked cycle by cycle against the phase schedule.
            send(3'd3, 16'h0123, a0);
            s_valid = 1'b0;
            for (int j = 1; j <= PER + OFF + 1; j++) begin
                k = j - OFF;
                if (j > 1) @(negedge clk);
                if (k >= 1 && k <= PER) begin
                    chk("wr_part",  32'(data_part_out), 32'((k <= S || k > PER - H) ? 1 : 0));
                    chk("wr_data",  32'(data_out),      32'((k <= S + H) ? 8'h23 : 8'h01));
                    chk("wr_addr",  32'(addr_out),      32'd3);
                    chk("wr_done",  32'(write_done),    32'(k == PER));
                    chk("wr_busy",  32'(busy),          32'd1);
                    chk("wr_ready", 32'(s_ready),       32'(FIFO_MODE));
                end else if (k == PER + 1) begin
                    chk("wr_end_ready", 32'(s_ready),       32'd1);
                    chk("wr_end_busy",  32'(busy),          32'd0);
                    chk("wr_end_part",  32'(data_part_out), 32'd1);
                    chk("wr_end_done",  32'(write_done),    32'd0);
                end else begin
                    chk("wr_queue_part", 32'(data_part_out), 32'd1);
                    chk("wr_queue_busy", 32'(busy),          32'd1);
                end
            end
            wait_idle();
            chk("dac_reg3", 32'(dac_reg[3]), 32'h0123);

            // Burst with s_valid held high.
            done_q.delete();
            for (int i = 0; i < NBURST; i++) begin
                send(ADDR_BITS'(i), 16'(16'h1111 * (i + 1)), a0);
                acc.push_back(a0);
            end
            s_valid = 1'b0;
            wait_idle();
            chk("burst_done_count", 32'(done_q.size()), 32'(NBURST));
            if (done_q.size() == NBURST) begin
                chk("burst_first_latency", 32'(done_q[0] - acc[0]), 32'(PER - 1 + OFF));
                for (int i = 1; i < NBURST; i++) begin
                    chk("burst_done_spacing", 32'(done_q[i] - done_q[i-1]),
                        32'(FIFO_MODE ? PER : PER + 1));
                    chk("burst_accept_spacing", 32'(acc[i] - acc[i-1]),
                        32'(FIFO_MODE ? ((i < 5) ? 1 : PER - 2) : PER + 1));
                end
            end
            for (int i = 0; i < NBURST; i++) begin
                chk("burst_reg", 32'(dac_reg[i]), 32'(16'h1111 * (i + 1)));
            end

            // Randomized writes with random gaps.
            for (int i = 0; i < 16; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                ra = ADDR_BITS'($urandom_range(0, 7));
                rd = 16'($urandom);
                send(ra, rd, a0);
                s_valid = 1'b0;
            end
            wait_idle();

            // Reset during HOLD_LO.
            send(3'd5, 16'hBEEF, a0);
            s_valid = 1'b0;
            repeat (OFF + S + 2) @(negedge clk);
            chk("pre_reset_part", 32'(data_part_out), 32'd0);
            #2;
            rst_n = 1'b0;
            #1;
            chk_reset_vals("async_reset");
            rd = exp_q.pop_back();
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk_reset_vals("post_reset");
            send(3'd5, 16'h5A5A, a0);
            s_valid = 1'b0;
            wait_idle();
            chk("reset_recover_reg5", 32'(dac_reg[5]), 32'h5A5A);

            chk("queue_empty", 32'(exp_q.size()), 32'd0);
            for (int i = 0; i < 8; i++) begin
                if (wr_mask[i]) chk("final_reg", 32'(dac_reg[i]), 32'(ref_reg[i]));
            end
            done_flag = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g_inst[0].done_flag && g_inst[1].done_flag) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (!(g_inst[0].done_flag && g_inst[1].done_flag)) begin
            checks++;
            errors++;
            $display("FAIL global_timeout: instances finished %b%b, expected 11",
                     g_inst[1].done_flag, g_inst[0].done_flag);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
